// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with a destination scoreboard.
// Two writeback requesters (A: ALU, B: load unit) share the single
// register-file write port. Contested cycles alternate priority
// between them, granted writes are registered onto the write port one
// cycle later, and a per-register busy bit tracks reserved destinations
// whose writes are still pending.
module regfile_wb_arbiter #(
    parameter int dtype    = 16,
    parameter int nregs    = 8,
    parameter int addr_len = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                a_valid,
    input  logic [addr_len-1:0] a_addr,
    input  logic [dtype-1:0]    a_data,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [addr_len-1:0] b_addr,
    input  logic [dtype-1:0]    b_data,
    output logic                b_ready,
    input  logic                rsv_valid,
    input  logic [addr_len-1:0] rsv_addr,
    output logic                wz_en,
    output logic [addr_len-1:0] wz_addr,
    output logic [dtype-1:0]    wz_data,
    output logic [nregs-1:0]    busy
);

    // Which requester wins when both are valid in the same cycle.
    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_t;

    pri_t                ptr;
    logic                xfer;
    logic [addr_len-1:0] sel_addr;
    logic [dtype-1:0]    sel_data;
    logic [nregs-1:0]    clr_mask;
    logic [nregs-1:0]    set_mask;

    // Grant: a lone requester always wins; a contested cycle goes to the
    // pointer's requester. Nothing is granted while frozen or in reset.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (reset && enable) begin
            if (a_valid && (!b_valid || ptr == PRI_A)) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    // Select the granted request's destination and value for the write port.
    always_comb begin
        xfer     = a_ready | b_ready;
        sel_addr = a_ready ? a_addr : b_addr;
        sel_data = a_ready ? a_data : b_data;
    end

    // Scoreboard edits for this cycle: clear the granted destination,
    // set the newly reserved one.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (xfer) begin
            clr_mask[sel_addr] = 1'b1;
        end
        if (rsv_valid && enable) begin
            set_mask[rsv_addr] = 1'b1;
        end
    end

    // Registered write port, priority pointer and scoreboard. The set mask
    // is OR-ed after the clear so a same-register set/clear leaves it busy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wz_en   <= 1'b0;
            wz_addr <= '0;
            wz_data <= '0;
            ptr     <= PRI_A;
            busy    <= '0;
        end else if (enable) begin
            wz_en <= xfer;
            if (xfer) begin
                wz_addr <= sel_addr;
                wz_data <= sel_data;
            end
            if (a_valid && b_valid) begin
                ptr <= a_ready ? PRI_B : PRI_A;
            end
            busy <= (busy & ~clr_mask) | set_mask;
        end else begin
            wz_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes expected
// register-file writes into a queue, a monitor pops and compares them
// against the write port, and a reference model tracks busy bits and
// arbitration priority.
module tb_regfile_wb_arbiter;

    localparam int DW = 16;
    localparam int NR = 8;
    localparam int AW = 3;

    logic          clock;
    logic          reset;
    logic          enable;
    logic          a_valid, b_valid, rsv_valid;
    logic [AW-1:0] a_addr, b_addr, rsv_addr;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready;
    logic          wz_en;
    logic [AW-1:0] wz_addr;
    logic [DW-1:0] wz_data;
    logic [NR-1:0] busy;

    regfile_wb_arbiter #(.dtype(DW), .nregs(NR), .addr_len(AW)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .wz_en(wz_en), .wz_addr(wz_addr), .wz_data(wz_data), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    // Reference model state
    wr_t           exp_q[$];
    bit            m_busy[NR];
    int            m_favor;          // 0: A wins a tie, 1: B wins a tie
    logic [AW-1:0] m_last_addr;
    logic [DW-1:0] m_last_data;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] model_busy();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        m_favor     = 0;
        m_last_addr = '0;
        m_last_data = '0;
        exp_q.delete();
    endtask

    // Monitor: each cycle the write port either shows the expected write or
    // stays idle holding its last values; the scoreboard must match the model.
    initial begin
        wr_t it;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                chk("wz_en_write", {31'd0, wz_en}, 32'd1);
                chk("wz_addr", {29'd0, wz_addr}, {29'd0, it.addr});
                chk("wz_data", {16'd0, wz_data}, {16'd0, it.data});
                m_last_addr = it.addr;
                m_last_data = it.data;
            end else begin
                chk("wz_en_idle", {31'd0, wz_en}, 32'd0);
                chk("wz_addr_hold", {29'd0, wz_addr}, {29'd0, m_last_addr});
                chk("wz_data_hold", {16'd0, wz_data}, {16'd0, m_last_data});
            end
            chk("busy", {24'd0, busy}, {24'd0, model_busy()});
        end
    end

    // One clock of stimulus: drive at negedge, check grants, update model at posedge.
    task automatic step(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                        input bit rv, input logic [AW-1:0] ra, input bit en,
                        output bit ga, output bit gb);
        wr_t w;
        @(negedge clock);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        rsv_valid = rv; rsv_addr = ra; enable = en;
        #1;
        ga = 1'b0;
        gb = 1'b0;
        if (en) begin
            if (av && bv) begin
                ga = (m_favor == 0);
                gb = (m_favor == 1);
            end else begin
                ga = av;
                gb = bv;
            end
        end
        chk("a_ready", {31'd0, a_ready}, {31'd0, ga});
        chk("b_ready", {31'd0, b_ready}, {31'd0, gb});
        @(posedge clock);
        if (en) begin
            if (ga || gb) begin
                w.addr = ga ? aa : ba;
                w.data = ga ? ad : bd;
                exp_q.push_back(w);
                m_busy[w.addr] = 1'b0;
            end
            if (rv) m_busy[ra] = 1'b1;
            if (av && bv) m_favor = ga ? 1 : 0;
        end
    endtask

    task automatic idle(input int n);
        bit ga, gb;
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 0, '0, 1, ga, gb);
    endtask

    // Assert reset between posedges with A requesting; effects must be immediate.
    task automatic do_reset();
        @(negedge clock);
        a_valid = 1'b1; a_addr = 3'd6; a_data = DW'($urandom);
        b_valid = 1'b0; rsv_valid = 1'b0; enable = 1'b1;
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        chk("rst_busy", {24'd0, busy}, 32'd0);
        chk("rst_wz_en", {31'd0, wz_en}, 32'd0);
        chk("rst_wz_addr", {29'd0, wz_addr}, 32'd0);
        chk("rst_wz_data", {16'd0, wz_data}, 32'd0);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        #2;
        a_valid = 1'b0;
        reset   = 1'b1;
    endtask

    initial begin
        bit            ga, gb;
        bit            a_p, b_p;
        logic [AW-1:0] a_pa, b_pa, ra;
        logic [DW-1:0] a_pd, b_pd;
        bit            rv, en;

        reset = 1'b0; enable = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0;
        model_clear();
        #2;
        chk("init_busy", {24'd0, busy}, 32'd0);
        chk("init_wz_en", {31'd0, wz_en}, 32'd0);
        #10 reset = 1'b1;

        // A alone: granted at once, written next cycle
        step(1, 3'd3, 16'h1234, 0, '0, '0, 0, '0, 1, ga, gb);
        idle(1);

        // Contested: alternates A,B,A,B
        for (int i = 0; i < 4; i++) step(1, 3'd1, 16'h1111, 1, 3'd2, 16'h2222, 0, '0, 1, ga, gb);
        idle(1);

        // Reserve r5, B writes it two cycles later
        step(0, '0, '0, 0, '0, '0, 1, 3'd5, 1, ga, gb);
        idle(1);
        step(0, '0, '0, 1, 3'd5, 16'h5555, 0, '0, 1, ga, gb);
        idle(1);

        // Reserve r4, then re-reserve it in the cycle A writes it
        step(0, '0, '0, 0, '0, '0, 1, 3'd4, 1, ga, gb);
        step(1, 3'd4, 16'h4444, 0, '0, '0, 1, 3'd4, 1, ga, gb);
        idle(1);
        // Set and clear of different registers together
        step(1, 3'd4, 16'h4040, 0, '0, '0, 1, 3'd0, 1, ga, gb);
        idle(1);

        // Frozen with both valid, then resume
        step(1, 3'd6, 16'h6666, 0, '0, '0, 0, '0, 1, ga, gb);
        step(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'hBBBB, 0, '0, 1, ga, gb);
        step(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'hBBBB, 1, 3'd7, 0, ga, gb);
        step(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'hBBBB, 0, '0, 0, ga, gb);
        step(1, 3'd1, 16'hAAAA, 1, 3'd2, 16'hBBBB, 0, '0, 1, ga, gb);
        idle(1);

        // Fill the scoreboard, then reset with A requesting
        for (int i = 0; i < NR; i++) step(0, '0, '0, 0, '0, '0, 1, AW'(i), 1, ga, gb);
        chk("busy_full", {24'd0, model_busy()}, 32'hFF);
        do_reset();
        idle(3);

        // Randomized traffic with requesters holding until granted
        a_p = 0; b_p = 0; a_pa = '0; b_pa = '0; a_pd = '0; b_pd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!a_p && ($urandom_range(2, 0) != 0)) begin
                a_p = 1; a_pa = AW'($urandom); a_pd = DW'($urandom);
            end
            if (!b_p && ($urandom_range(2, 0) != 0)) begin
                b_p = 1; b_pa = AW'($urandom); b_pd = DW'($urandom);
            end
            rv = ($urandom_range(2, 0) == 0);
            ra = AW'($urandom);
            en = ($urandom_range(9, 0) != 0);
            step(a_p, a_pa, a_pd, b_p, b_pa, b_pd, rv, ra, en, ga, gb);
            if (ga) a_p = 0;
            if (gb) b_p = 0;
            if (c == 200) begin
                do_reset();
                a_p = 0;
                b_p = 0;
            end
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: dtype, 16, data width of register write data.
REQ-002 Parameter: nregs, 8, number of architectural registers.
REQ-003 Parameter: addr_len, 3, register address width (nregs = 2**addr_len).
REQ-004 clock  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  global advance; low freezes all state, no grants.
REQ-007 a_valid  input  1  requester A (ALU writeback) write request.
REQ-008 a_addr / a_data  input  addr_len / dtype  requester A destination and value.
REQ-009 a_ready  output  1  A request accepted this cycle.
REQ-010 b_valid  input  1  requester B (load unit) write request.
REQ-011 b_addr / b_data  input  addr_len / dtype  requester B destination and value.
REQ-012 b_ready  output  1  B request accepted this cycle.
REQ-013 rsv_valid / rsv_addr  input  1 / addr_len  issue-stage reservation of a destination register.
REQ-014 wz_en  output  1  register-file write enable (drives its clk_en).
REQ-015 wz_addr / wz_data  output  addr_len / dtype  register-file write address and data (rZ_address / rZ).
REQ-016 busy  output  nregs  scoreboard; bit n set = register n has a write pending.

Function
REQ-017 Handshake: transfer occurs on posedge where x_valid & x_ready & enable; requester holds valid/addr/data stable until transfer.
REQ-018 x_ready combinational from valids, enable and priority pointer; at most one of a_ready/b_ready high per cycle.
REQ-019 Only one valid: that requester granted. Both valid: pointer requester granted. enable low: both ready low.
REQ-020 Priority pointer: 1 bit, 0 = A first; after a contested grant (both valid), pointer moves to the loser; uncontested grants leave pointer unchanged.
REQ-021 Latency 1: cycle after a transfer, wz_en=1 with registered addr/data of granted request; cycle with no transfer, wz_en=0 and wz_addr/wz_data hold last values.
REQ-022 Back-to-back transfers sustain one write per cycle; no bubble.
REQ-023 Scoreboard set: rsv_valid & enable sets busy[rsv_addr] at posedge.
REQ-024 Scoreboard clear: transfer sets clear of busy[granted addr] at the same posedge the write is registered (busy drops together with wz_en rising).
REQ-025 Same-cycle set and clear of same register: set wins (busy stays 1, new pending write).
REQ-026 Set and clear of different registers same cycle: both applied.
REQ-027 Write to non-busy register is legal; clear is a no-op on already-clear bit.
REQ-028 enable low: busy, pointer, wz_addr/wz_data hold; wz_en forced 0 next cycle.

Reset
REQ-029 reset low asynchronously forces: busy=0, pointer=0, wz_en=0, wz_addr=0, wz_data=0.
REQ-030 a_ready/b_ready low while reset low; reset mid-transfer discards the in-flight request (no write issued after release).
REQ-031 First grant eligible at first posedge with reset high.

Verification
REQ-032 A only: a_valid=1, a_addr=3, a_data=16'h1234 -> a_ready=1 same cycle; next cycle wz_en=1, wz_addr=3, wz_data=16'h1234.
REQ-033 Both valid 4 cycles, A addr 1, B addr 2, after reset -> grants A,B,A,B; wz_addr 1,2,1,2 on consecutive cycles.
REQ-034 rsv_valid addr 5, then B writes addr 5 two cycles later -> busy[5]=1 for two cycles, 0 with wz_en.
REQ-035 rsv_valid addr 4 and A transfer addr 4 same cycle with busy[4]=1 -> busy[4] remains 1; wz_addr=4 written.
REQ-036 enable=0 with both valid -> no ready, wz_en=0, busy and pointer unchanged; enable=1 resumes with pointer requester.
REQ-037 Assert reset low between posedges with busy=8'hFF and A valid -> busy=0, wz_en=0 immediately; no write after release until new request.
